// File: rtl/sec_timer_pkg.sv
// Shared definitions for the seconds-resolution timer arbiter: FSM state codes
// and the prescaler divide/width helpers.
package sec_timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // A divide-by-2 still needs one counter bit.
  function automatic int presc_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter with synchronous clear; wrap pulses in the cycle
// the counter sits at DIV-1 while enabled. No backpressure, wrap is combinational from state.
module tick_prescaler
  import sec_timer_pkg::*;
#(
  parameter int DIV   = 10,
  parameter int CNT_W = presc_width(DIV)
) (
  input  logic clk_100m,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // wrap ignores clr so the owner FSM can see the final tick in the same
  // cycle it decides to leave RUN (which is what raises clr).
  assign wrap = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sec_timer_arbiter.sv
// Round-robin owner of one shared seconds countdown; grant 1 cycle after req in IDLE,
// done exactly dur*DIV cycles after grant. Requesters wait (hold req) while another owns it.
module sec_timer_arbiter
  import sec_timer_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int DUR_W   = 8
) (
  input  logic                   clk_100m,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [DUR_W-1:0]       remaining,
  output logic                   tick
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int PTR_W = $clog2(N_REQ);

  state_t           state_q,  state_d;
  logic [PTR_W-1:0] owner_q,  owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [DUR_W-1:0] rem_q,    rem_d;

  logic [DUR_W-1:0] dur_arr [N_REQ];
  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand_idx;
  int               cand;
  logic [PTR_W-1:0] ptr_after;
  logic [N_REQ-1:0] owner_oh;
  logic             presc_clr;
  logic             presc_en;
  logic             presc_wrap;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      dur_arr[i] = dur[i*DUR_W +: DUR_W];
    end
  end

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % N_REQ;
      cand_idx = PTR_W'(cand);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  assign ptr_after = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_RUN;
          owner_d = pick_idx;
          rem_d   = dur_arr[pick_idx];
        end
      end
      ST_RUN: begin
        // Abort outranks completion: a dropped req never yields done.
        if (!req[owner_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ptr_after;
          rem_d    = '0;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (presc_wrap) begin
          rem_d = rem_q - DUR_W'(1);
          if (rem_q == DUR_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = ptr_after;
        rem_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Held at zero outside RUN so every grant starts a full, exact interval.
  assign presc_clr = (state_q != ST_RUN) || (state_d != ST_RUN);
  assign presc_en  = (state_q == ST_RUN) && (rem_q != '0);

  tick_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk_100m (clk_100m),
    .rst      (rst),
    .clr      (presc_clr),
    .en       (presc_en),
    .wrap     (presc_wrap)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign gnt       = (state_q != ST_IDLE) ? owner_oh : '0;
  assign done      = (state_q == ST_DONE) ? owner_oh : '0;
  assign busy      = (state_q != ST_IDLE);
  assign remaining = rem_q;
  assign tick      = presc_wrap;

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      rem_q    <= rem_d;
    end
  end

endmodule
